mem_bist_ctrl: RTL and testbench

//  Parametrised memory test controller for native-interface RAMs (wr/rd enable + addr).

---
 rtl/mem_bist_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_bist_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bist_ctrl.sv
// Memory BIST controller: writes a selectable pattern to addresses 0..DEPTH-1, reads it
// back through an RD_LATENCY-deep checker pipe, and counts mismatches.
module mem_bist_ctrl #(
    parameter int ADDR_WIDTH = 18,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2**ADDR_WIDTH,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [1:0]            pattern,
    input  logic                  loop,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           err_cnt,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data
);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_e;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [1:0]            LAST_DRAIN = 2'(RD_LATENCY - 1);

    function automatic logic [DATA_WIDTH-1:0] pattern_data(input logic [1:0]            pat,
                                                           input logic [ADDR_WIDTH-1:0] a);
        logic [DATA_WIDTH-1:0] a_ext;
        logic [DATA_WIDTH-1:0] cboard;
        a_ext = DATA_WIDTH'(a);
        for (int i = 0; i < DATA_WIDTH; i++) cboard[i] = (i % 2 == 1);
        case (pat)
            2'd0:    pattern_data = a_ext;
            2'd1:    pattern_data = ~a_ext;
            2'd2:    pattern_data = a[0] ? ~cboard : cboard;
            default: pattern_data = '1;
        endcase
    endfunction

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [1:0]              drain_q, drain_d;
    logic [1:0]              pat_q, pat_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    pass_q, pass_d;
    logic [15:0]             err_cnt_q, err_cnt_d;
    logic [ADDR_WIDTH-1:0]   first_err_q, first_err_d;
    logic                    err_seen_q, err_seen_d;
    logic                    wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                    rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic [RD_LATENCY-1:0]   pipe_vld_q, pipe_vld_d;
    logic [DATA_WIDTH-1:0]   pipe_exp_q  [RD_LATENCY];
    logic [DATA_WIDTH-1:0]   pipe_exp_d  [RD_LATENCY];
    logic [ADDR_WIDTH-1:0]   pipe_addr_q [RD_LATENCY];
    logic [ADDR_WIDTH-1:0]   pipe_addr_d [RD_LATENCY];

    logic start_hit, abort_hit, last_addr, mismatch;

    assign start_hit = (state_q == S_IDLE) && start;
    assign abort_hit = (state_q != S_IDLE) && abort;
    assign last_addr = (addr_q == LAST_ADDR);

    // NOTE: state and outputs update with non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races between flops.
    // NOTE: the checker delay line is reset alongside the control flops so no stale read
    // can be compared after reset; it is a few registers, not a RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            drain_q     <= '0;
            pat_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            err_seen_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            pipe_vld_q  <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_exp_q[i]  <= '0;
                pipe_addr_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            drain_q     <= drain_d;
            pat_q       <= pat_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            err_seen_q  <= err_seen_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_exp_q  <= pipe_exp_d;
            pipe_addr_q <= pipe_addr_d;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        drain_d = drain_q;
        pat_d   = pat_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_WRITE;
                addr_d  = '0;
                pat_d   = pattern;
            end
            S_WRITE: begin
                addr_d = last_addr ? '0 : addr_q + ADDR_WIDTH'(1);
                if (last_addr) state_d = S_READ;
            end
            S_READ: begin
                addr_d = last_addr ? '0 : addr_q + ADDR_WIDTH'(1);
                if (last_addr) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end
            end
            S_DRAIN: begin
                drain_d = drain_q + 2'd1;
                if (drain_q == LAST_DRAIN) state_d = S_DONE;
            end
            S_DONE: begin
                if (loop) begin
                    state_d = S_WRITE;
                    addr_d  = '0;
                    pat_d   = pat_q + 2'd1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort_hit) begin
            state_d = S_IDLE;
            addr_d  = '0;
        end
    end

    // Outputs are registered from the next state, so strobes line up with the state itself.
    // Anything not yet compared when abort lands is discarded and err_cnt holds.
    always_comb begin
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        wr_en_d   = (state_d == S_WRITE);
        wr_addr_d = wr_en_d ? addr_d : '0;
        wr_data_d = wr_en_d ? pattern_data(pat_d, addr_d) : '0;
        rd_en_d   = (state_d == S_READ);
        rd_addr_d = rd_en_d ? addr_d : '0;

        pipe_vld_d     = '0;
        pipe_exp_d     = pipe_exp_q;
        pipe_addr_d    = pipe_addr_q;
        pipe_exp_d[0]  = pattern_data(pat_q, rd_addr_q);
        pipe_addr_d[0] = rd_addr_q;
        if (!abort_hit) pipe_vld_d[0] = rd_en_q;
        for (int i = 1; i < RD_LATENCY; i++) begin
            if (!abort_hit) pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_exp_d[i]  = pipe_exp_q[i-1];
            pipe_addr_d[i] = pipe_addr_q[i-1];
        end

        mismatch = pipe_vld_q[RD_LATENCY-1] && !abort_hit &&
                   (rd_data != pipe_exp_q[RD_LATENCY-1]);

        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        err_seen_d  = err_seen_q;
        pass_d      = pass_q;
        if (start_hit) begin
            err_cnt_d   = '0;
            first_err_d = '0;
            err_seen_d  = 1'b0;
            pass_d      = 1'b0;
        end else if (mismatch) begin
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            if (!err_seen_q) begin
                first_err_d = pipe_addr_q[RD_LATENCY-1];
                err_seen_d  = 1'b1;
            end
        end
        if (state_d == S_DONE) pass_d = (err_cnt_d == 16'd0);
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_cnt        = err_cnt_q;
    assign first_err_addr = first_err_q;
    assign wr_en          = wr_en_q;
    assign wr_addr        = wr_addr_q;
    assign wr_data        = wr_data_q;
    assign rd_en          = rd_en_q;
    assign rd_addr        = rd_addr_q;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl: two instances (DEPTH=16/RD_LATENCY=2 and DEPTH=12/RD_LATENCY=1)
// against ideal RAM models with injectable read faults and a done-pulse scoreboard.
module tb_mem_bist_ctrl;

    localparam int DW      = 32;
    localparam int AW_A    = 8;
    localparam int DEPTH_A = 16;
    localparam int RL_A    = 2;
    localparam int AW_B    = 4;
    localparam int DEPTH_B = 12;
    localparam int RL_B    = 1;

    logic clk = 1'b0;
    logic rst_n, start, abort, loop_a, loop_b;
    logic [1:0] pattern;
    int fault;

    logic            busy_a, done_a, pass_a, wr_en_a, rd_en_a;
    logic [15:0]     err_cnt_a;
    logic [AW_A-1:0] first_err_addr_a, wr_addr_a, rd_addr_a;
    logic [DW-1:0]   wr_data_a, rd_data_a;
    logic            busy_b, done_b, pass_b, wr_en_b, rd_en_b;
    logic [15:0]     err_cnt_b;
    logic [AW_B-1:0] first_err_addr_b, wr_addr_b, rd_addr_b;
    logic [DW-1:0]   wr_data_b, rd_data_b;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mem_bist_ctrl #(.ADDR_WIDTH(AW_A), .DATA_WIDTH(DW), .DEPTH(DEPTH_A), .RD_LATENCY(RL_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pattern(pattern), .loop(loop_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_cnt_a),
        .first_err_addr(first_err_addr_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
        .wr_data(wr_data_a), .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a));

    mem_bist_ctrl #(.ADDR_WIDTH(AW_B), .DATA_WIDTH(DW), .DEPTH(DEPTH_B), .RD_LATENCY(RL_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pattern(pattern), .loop(loop_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_cnt_b),
        .first_err_addr(first_err_addr_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
        .wr_data(wr_data_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_data(input int pat, input int a);
        case (pat)
            0:       return DW'(a);
            1:       return ~DW'(a);
            2:       return (a % 2 == 0) ? 32'hAAAA_AAAA : 32'h5555_5555;
            default: return '1;
        endcase
    endfunction

    // fault 1: bit 0 flipped at address 5; fault 2: data bit 31 stuck at 0
    function automatic logic [DW-1:0] corrupt(input logic [DW-1:0] d, input int a);
        case (fault)
            1:       return (a == 5) ? d ^ 32'h1 : d;
            2:       return d & 32'h7FFF_FFFF;
            default: return d;
        endcase
    endfunction

    logic [DW-1:0] mem_a [2**AW_A];
    logic [DW-1:0] pipe_a [RL_A];
    logic [DW-1:0] mem_b [2**AW_B];
    logic [DW-1:0] pipe_b [RL_B];

    always @(posedge clk) begin
        if (wr_en_a) mem_a[wr_addr_a] <= wr_data_a;
        pipe_a[0] <= corrupt(mem_a[rd_addr_a], int'(rd_addr_a));
        for (int i = 1; i < RL_A; i++) pipe_a[i] <= pipe_a[i-1];
        if (wr_en_b) mem_b[wr_addr_b] <= wr_data_b;
        pipe_b[0] <= corrupt(mem_b[rd_addr_b], int'(rd_addr_b));
    end
    assign rd_data_a = pipe_a[RL_A-1];
    assign rd_data_b = pipe_b[RL_B-1];

    typedef struct {
        int cyc;
        int err;
        bit pass;
        int first;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;

    // One record per expected done pulse: first done 2*DEPTH+RL edges after start is
    // sampled, later loop passes every 2*DEPTH+RL+1 edges.
    task automatic push_run(input bit is_b, input int pat, input int passes, input int sc);
        int depth, rl, cum, first, p;
        bit seen;
        exp_t e;
        logic [DW-1:0] d;
        depth = is_b ? DEPTH_B : DEPTH_A;
        rl    = is_b ? RL_B : RL_A;
        cum   = 0;
        first = 0;
        seen  = 1'b0;
        for (int k = 0; k < passes; k++) begin
            p = (pat + k) % 4;
            for (int a = 0; a < depth; a++) begin
                d = exp_data(p, a);
                if (corrupt(d, a) != d) begin
                    cum++;
                    if (!seen) begin
                        seen  = 1'b1;
                        first = a;
                    end
                end
            end
            e.cyc   = sc + 2 * depth + rl + k * (2 * depth + rl + 1);
            e.err   = cum;
            e.pass  = (cum == 0);
            e.first = first;
            if (is_b) q_b.push_back(e);
            else      q_a.push_back(e);
        end
    endtask

    int wr_idx_a, rd_idx_a, pat_a, wr_idx_b, rd_idx_b, pat_b;

    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en_a || rd_en_a) check("strobe_excl_a", wr_en_a & rd_en_a, 0);
            if (wr_en_a) begin
                check("wr_addr_a", wr_addr_a, wr_idx_a);
                check("wr_data_a", wr_data_a, exp_data(pat_a, wr_idx_a));
                wr_idx_a = (wr_idx_a + 1) % DEPTH_A;
            end
            if (rd_en_a) begin
                check("rd_addr_a", rd_addr_a, rd_idx_a);
                rd_idx_a = (rd_idx_a + 1) % DEPTH_A;
            end
            if (done_a) begin
                if (q_a.size() == 0) check("unexpected_done_a", done_a, 0);
                else begin
                    e_a = q_a.pop_front();
                    check("done_cycle_a", cyc, e_a.cyc);
                    check("err_cnt_a", err_cnt_a, e_a.err);
                    check("pass_a", pass_a, e_a.pass);
                    check("first_err_a", first_err_addr_a, e_a.first);
                    pat_a = (pat_a + 1) % 4;
                end
            end
            if (loop_a && wr_en_a && q_a.size() == 1) loop_a = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en_b || rd_en_b) check("strobe_excl_b", wr_en_b & rd_en_b, 0);
            if (wr_en_b) begin
                check("wr_addr_b", wr_addr_b, wr_idx_b);
                check("wr_data_b", wr_data_b, exp_data(pat_b, wr_idx_b));
                wr_idx_b = (wr_idx_b + 1) % DEPTH_B;
            end
            if (rd_en_b) begin
                check("rd_addr_b", rd_addr_b, rd_idx_b);
                rd_idx_b = (rd_idx_b + 1) % DEPTH_B;
            end
            if (done_b) begin
                if (q_b.size() == 0) check("unexpected_done_b", done_b, 0);
                else begin
                    e_b = q_b.pop_front();
                    check("done_cycle_b", cyc, e_b.cyc);
                    check("err_cnt_b", err_cnt_b, e_b.err);
                    check("pass_b", pass_b, e_b.pass);
                    check("first_err_b", first_err_addr_b, e_b.first);
                    pat_b = (pat_b + 1) % 4;
                end
            end
            if (loop_b && wr_en_b && q_b.size() == 1) loop_b = 1'b0;
        end
    end

    task automatic pulse_start(input int pat, input int passes);
        int sc;
        @(negedge clk);
        pattern  = 2'(pat);
        start    = 1'b1;
        sc       = cyc + 1;
        wr_idx_a = 0;
        rd_idx_a = 0;
        wr_idx_b = 0;
        rd_idx_b = 0;
        pat_a    = pat;
        pat_b    = pat;
        push_run(1'b0, pat, passes, sc);
        push_run(1'b1, pat, passes, sc);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((q_a.size() != 0 || q_b.size() != 0 || busy_a || busy_b) && n < max_cyc);
        if (n >= max_cyc)
            check("idle_timeout", q_a.size() + q_b.size() + int'(busy_a) + int'(busy_b), 0);
    endtask

    task automatic wait_addr_a(input bit rd, input int addr);
        int n;
        n = 0;
        while (!(rd ? (rd_en_a && int'(rd_addr_a) == addr) : (wr_en_a && int'(wr_addr_a) == addr))
               && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check(rd ? "wait_rd_addr_a" : "wait_wr_addr_a", n, 0);
    endtask

    typedef struct {
        int pat;
        int passes;
        int fault;
        int err_a;
        int first_a;
        bit pass_a;
    } vec_t;

    vec_t vecs [6];

    task automatic run_vec(input vec_t v);
        fault  = v.fault;
        loop_a = (v.passes > 1);
        loop_b = (v.passes > 1);
        pulse_start(v.pat, v.passes);
        wait_idle(3000);
        check("vec_err_cnt_a", err_cnt_a, v.err_a);
        check("vec_first_err_a", first_err_addr_a, v.first_a);
        check("vec_pass_a", pass_a, v.pass_a);
        check("vec_busy_a", busy_a, 0);
    endtask

    initial begin
        // {pattern, passes, fault, final err_cnt, first_err_addr, pass} for the DEPTH=16 unit
        vecs[0] = '{0, 1, 0, 0, 0, 1'b1};
        vecs[1] = '{0, 1, 1, 1, 5, 1'b0};
        vecs[2] = '{2, 1, 0, 0, 0, 1'b1};
        vecs[3] = '{3, 4, 2, 40, 0, 1'b0};
        vecs[4] = '{1, 1, 1, 1, 5, 1'b0};
        vecs[5] = '{2, 1, 2, 8, 0, 1'b0};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; pattern = 2'd0;
        loop_a = 1'b0; loop_b = 1'b0; fault = 0;
        for (int i = 0; i < 2**AW_A; i++) mem_a[i] = '0;
        for (int i = 0; i < 2**AW_B; i++) mem_b[i] = '0;

        repeat (3) @(negedge clk);
        check("rst_busy_a", busy_a, 0);
        check("rst_outputs_a", {done_a, pass_a, wr_en_a, rd_en_a, err_cnt_a, first_err_addr_a}, 0);
        check("rst_buses_a", {wr_addr_a, rd_addr_a, wr_data_a}, 0);
        check("rst_outputs_b", {busy_b, done_b, pass_b, wr_en_b, rd_en_b, err_cnt_b}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy_a", busy_a, 0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Abort during READ at address 7; a mid-test start with another pattern is ignored.
        fault  = 2;
        loop_a = 1'b0;
        loop_b = 1'b0;
        pulse_start(3, 0);
        wait_addr_a(1'b0, 3);
        pattern = 2'd1;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_addr_a(1'b1, 7);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy_a", busy_a, 0);
        check("abort_rd_en_a", rd_en_a, 0);
        check("abort_done_a", done_a, 0);
        check("abort_err_cnt_a", err_cnt_a, 5);
        check("abort_err_cnt_b", err_cnt_b, 10);
        repeat (40) @(negedge clk);
        check("abort_hold_err_a", err_cnt_a, 5);
        check("abort_stay_idle", {busy_a, busy_b}, 0);

        // Reset pulse during WRITE, then a clean pass.
        fault = 0;
        pulse_start(0, 0);
        wait_addr_a(1'b0, 4);
        check("pre_rst_wr_data_a", wr_data_a, 4);
        rst_n = 1'b0;
        #1;
        check("mid_rst_outputs_a", {busy_a, done_a, pass_a, wr_en_a, rd_en_a, err_cnt_a}, 0);
        check("mid_rst_buses_a", {wr_addr_a, rd_addr_a, wr_data_a, first_err_addr_a}, 0);
        check("mid_rst_outputs_b", {busy_b, wr_en_b, wr_addr_b, wr_data_b}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_busy_a", busy_a, 0);
        run_vec(vecs[0]);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
